// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous memory between the CPU load/store port and
// the VGA fetch engine. VGA wins by default; a starvation counter forces a CPU grant.
// Optional grant statistics are compiled in with the ARB_STATS_EN macro.
module mem_arbiter #(
    parameter int Abits    = 32,
    parameter int Dbits    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [Abits-1:0] cpu_addr,
    input  logic [Dbits-1:0] cpu_wdata,
    output logic [Dbits-1:0] cpu_rdata,
    output logic             cpu_ready,
    input  logic             vga_req,
    input  logic [Abits-1:0] vga_addr,
    output logic [Dbits-1:0] vga_rdata,
    output logic             vga_valid,
    output logic             mem_en,
    output logic             mem_we,
    output logic [Abits-1:0] mem_addr,
    output logic [Dbits-1:0] mem_wdata,
    input  logic [Dbits-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]      stat_cpu_grants,
    output logic [31:0]      stat_vga_grants,
    output logic [15:0]      stat_cpu_forced
`endif
);

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VGA} owner_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    owner_t           owner_q, owner_d;
    logic             cpu_busy_q, cpu_busy_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic [Dbits-1:0] cpu_rdata_q;
    logic [Dbits-1:0] vga_rdata_q;
    logic             cpu_elig;
    logic             grant_cpu;
    logic             grant_vga;
    logic             forced;

    assign cpu_ready = (owner_q == OWN_CPU);
    assign vga_valid = (owner_q == OWN_VGA);
    assign cpu_rdata = cpu_ready ? mem_rdata : cpu_rdata_q;
    assign vga_rdata = vga_valid ? mem_rdata : vga_rdata_q;
    // Ineligible during its own ready cycle so a still-high request is not serviced twice.
    assign cpu_elig  = cpu_req & ~cpu_busy_q & ~cpu_ready;

    always_comb begin
        owner_d    = OWN_NONE;
        cpu_busy_d = cpu_busy_q;
        wait_cnt_d = wait_cnt_q;
        grant_cpu  = 1'b0;
        grant_vga  = 1'b0;
        forced     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (owner_q == OWN_CPU) begin
            cpu_busy_d = 1'b0;
        end
        // Outputs are forced quiet while reset is held, even with live requests.
        if (reset) begin
            if (cpu_elig && (wait_cnt_q == MAX_W)) begin
                grant_cpu = 1'b1;
                forced    = 1'b1;
            end else if (vga_req) begin
                grant_vga = 1'b1;
            end else if (cpu_elig) begin
                grant_cpu = 1'b1;
            end
        end
        if (grant_cpu) begin
            mem_en     = 1'b1;
            mem_we     = cpu_we;
            mem_addr   = cpu_addr;
            mem_wdata  = cpu_wdata;
            owner_d    = OWN_CPU;
            cpu_busy_d = 1'b1;
            wait_cnt_d = '0;
        end else if (grant_vga) begin
            mem_en  = 1'b1;
            mem_addr = vga_addr;
            owner_d = OWN_VGA;
            if (cpu_elig && (wait_cnt_q != MAX_W)) begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q     <= OWN_NONE;
            cpu_busy_q  <= 1'b0;
            wait_cnt_q  <= '0;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            owner_q    <= owner_d;
            cpu_busy_q <= cpu_busy_d;
            wait_cnt_q <= wait_cnt_d;
            if (owner_q == OWN_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (owner_q == OWN_VGA) begin
                vga_rdata_q <= mem_rdata;
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_cpu_grants <= '0;
            stat_vga_grants <= '0;
            stat_cpu_forced <= '0;
        end else begin
            if (grant_cpu) begin
                stat_cpu_grants <= stat_cpu_grants + 32'd1;
            end
            if (grant_vga) begin
                stat_vga_grants <= stat_vga_grants + 32'd1;
            end
            if (forced) begin
                stat_cpu_forced <= stat_cpu_forced + 16'd1;
            end
        end
    end
`endif

endmodule
